// File: rtl/jtag_tap_target.sv
// -----------------------------------------------------------------------------
// jtag_tap_target
//
// IEEE 1149.1-style TAP target oversampled on the system clock. tck_i is
// produced in the clk domain by the on-chip JTAG master, so rising/falling
// tck edges are detected with a single history register and every TAP action
// happens on the clk cycle in which an edge is seen.
//
// Data registers: IDCODE (32 bit), BYPASS (1 bit), USER (USER_W bits).
// USER captures cap_data_i at Capture-DR and publishes its shifted contents on
// upd_data_o at Update-DR.
//
// Handshake: cap_pulse_o and upd_valid_o are single-clk pulses with no
// back-pressure; downstream logic must accept them in the cycle they appear.
// cap_data_i must be valid in the clk cycle of the Capture-DR tck rise, and
// upd_data_o is valid from the cycle upd_valid_o is high until the next
// Update-DR under USER (or rst).
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   tck_i, tms_i,
//   tdi_i, trst_i   JTAG pins from the master (trst_i active-low)
//   tdo_o           test data out, changes only on tck falling edges
//   cap_data_i      value loaded into USER at Capture-DR
//   cap_pulse_o     one-clk pulse when USER is captured
//   upd_data_o      last USER value committed at Update-DR
//   upd_valid_o     one-clk pulse when upd_data_o is updated
//   tap_state_o     current TAP state (debug visibility)
//   ir_o            current instruction
// -----------------------------------------------------------------------------
module jtag_tap_target #(
    parameter int                IR_W       = 4,
    parameter int                USER_W     = 24,
    parameter logic [31:0]       IDCODE_VAL = 32'h1000_5A6B,
    parameter logic [IR_W-1:0]   INS_IDCODE = 4'h1,
    parameter logic [IR_W-1:0]   INS_USER   = 4'h8,
    parameter logic [IR_W-1:0]   INS_BYPASS = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tck_i,
    input  logic              tms_i,
    input  logic              tdi_i,
    input  logic              trst_i,
    output logic              tdo_o,
    input  logic [USER_W-1:0] cap_data_i,
    output logic              cap_pulse_o,
    output logic [USER_W-1:0] upd_data_o,
    output logic              upd_valid_o,
    output logic [3:0]        tap_state_o,
    output logic [IR_W-1:0]   ir_o
);

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_t;

    tap_state_t        state;
    tap_state_t        state_nxt;
    logic              tck_q;
    logic              rise;
    logic              fall;
    logic [IR_W-1:0]   ir;
    logic [IR_W-1:0]   ir_shift;
    logic [31:0]       idcode_shift;
    logic [USER_W-1:0] user_shift;
    logic              bypass_reg;
    logic              sel_idcode;
    logic              sel_user;
    logic              sel_bypass;
    logic              dr_lsb;

    assign rise = tck_i & ~tck_q;
    assign fall = ~tck_i & tck_q;

    assign sel_idcode = (ir == INS_IDCODE);
    assign sel_user   = (ir == INS_USER);
    // The explicit BYPASS opcode and every unlisted opcode share one register.
    assign sel_bypass = (ir == INS_BYPASS) | ~(sel_idcode | sel_user);

    assign dr_lsb = sel_idcode ? idcode_shift[0] :
                    sel_user   ? user_shift[0]   : bypass_reg;

    assign tap_state_o = state;
    assign ir_o        = ir;

    // Standard 1149.1 state graph, evaluated against the tms value present at
    // the tck rising edge.
    always_comb begin
        state_nxt = state;
        case (state)
            TLR:      state_nxt = tms_i ? TLR      : RTI;
            RTI:      state_nxt = tms_i ? SEL_DR   : RTI;
            SEL_DR:   state_nxt = tms_i ? SEL_IR   : CAP_DR;
            CAP_DR:   state_nxt = tms_i ? EX1_DR   : SH_DR;
            SH_DR:    state_nxt = tms_i ? EX1_DR   : SH_DR;
            EX1_DR:   state_nxt = tms_i ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_nxt = tms_i ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_nxt = tms_i ? UPD_DR   : SH_DR;
            UPD_DR:   state_nxt = tms_i ? SEL_DR   : RTI;
            SEL_IR:   state_nxt = tms_i ? TLR      : CAP_IR;
            CAP_IR:   state_nxt = tms_i ? EX1_IR   : SH_IR;
            SH_IR:    state_nxt = tms_i ? EX1_IR   : SH_IR;
            EX1_IR:   state_nxt = tms_i ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_nxt = tms_i ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_nxt = tms_i ? UPD_IR   : SH_IR;
            UPD_IR:   state_nxt = tms_i ? SEL_DR   : RTI;
            default:  state_nxt = TLR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= TLR;
            tck_q        <= 1'b0;
            ir           <= INS_IDCODE;
            ir_shift     <= '0;
            idcode_shift <= '0;
            user_shift   <= '0;
            bypass_reg   <= 1'b0;
            tdo_o        <= 1'b0;
            cap_pulse_o  <= 1'b0;
            upd_valid_o  <= 1'b0;
            upd_data_o   <= '0;
        end else begin
            // tck history keeps tracking during trst so that releasing trst
            // never produces a phantom edge.
            tck_q       <= tck_i;
            cap_pulse_o <= 1'b0;
            upd_valid_o <= 1'b0;

            if (!trst_i) begin
                state <= TLR;
                ir    <= INS_IDCODE;
            end else if (rise) begin
                case (state)
                    CAP_IR: ir_shift <= {{(IR_W-2){1'b0}}, 2'b01};
                    SH_IR:  ir_shift <= {tdi_i, ir_shift[IR_W-1:1]};
                    UPD_IR: ir       <= ir_shift;
                    CAP_DR: begin
                        if (sel_idcode) idcode_shift <= IDCODE_VAL;
                        if (sel_user) begin
                            user_shift  <= cap_data_i;
                            cap_pulse_o <= 1'b1;
                        end
                        if (sel_bypass) bypass_reg <= 1'b0;
                    end
                    SH_DR: begin
                        if (sel_idcode) idcode_shift <= {tdi_i, idcode_shift[31:1]};
                        if (sel_user)   user_shift   <= {tdi_i, user_shift[USER_W-1:1]};
                        if (sel_bypass) bypass_reg   <= tdi_i;
                    end
                    UPD_DR: begin
                        if (sel_user) begin
                            upd_data_o  <= user_shift;
                            upd_valid_o <= 1'b1;
                        end
                    end
                    default: ;
                endcase

                state <= state_nxt;
                if (state_nxt == TLR) ir <= INS_IDCODE;
            end else if (fall) begin
                // Launched on the falling edge so it is stable for the whole
                // following tck-high phase where the master samples it.
                case (state)
                    SH_IR:   tdo_o <= ir_shift[0];
                    SH_DR:   tdo_o <= dr_lsb;
                    default: tdo_o <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_target.sv
// -----------------------------------------------------------------------------
// tb_jtag_tap_target
//
// Drives the JTAG pins at tck level and keeps a queue-based model of the TAP:
// each data/instruction register is a bit queue (front = bit shifted out next),
// captures refill the queue, shifts pop the front and push tdi at the back.
// Every clk cycle goes through tick(), which compares all DUT outputs with the
// model.
// -----------------------------------------------------------------------------
module tb_jtag_tap_target;

  localparam int          IR_W       = 4;
  localparam int          USER_W     = 24;
  localparam logic [31:0] IDCODE_VAL = 32'h1000_5A6B;
  localparam logic [3:0]  INS_IDCODE = 4'h1;
  localparam logic [3:0]  INS_USER   = 4'h8;
  localparam logic [3:0]  INS_BYPASS = 4'hF;

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6,
                         S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PAUSEDR = 4'h3, S_EX2DR = 4'h0,
                         S_UPDDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA,
                         S_EX1IR = 4'h9, S_PAUSEIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              tck, tms, tdi, trst;
  logic              tdo_o;
  logic [USER_W-1:0] cap_data;
  logic              cap_pulse_o;
  logic [USER_W-1:0] upd_data_o;
  logic              upd_valid_o;
  logic [3:0]        tap_state_o;
  logic [IR_W-1:0]   ir_o;

  jtag_tap_target dut (
    .clk         (clk),
    .rst         (rst),
    .tck_i       (tck),
    .tms_i       (tms),
    .tdi_i       (tdi),
    .trst_i      (trst),
    .tdo_o       (tdo_o),
    .cap_data_i  (cap_data),
    .cap_pulse_o (cap_pulse_o),
    .upd_data_o  (upd_data_o),
    .upd_valid_o (upd_valid_o),
    .tap_state_o (tap_state_o),
    .ir_o        (ir_o)
  );

  // ---------------- model ----------------
  logic [3:0]        m_state;
  logic [IR_W-1:0]   m_ir;
  bit                m_ir_q[$];
  bit                m_dr_q[$];
  logic              m_tdo;
  logic              m_cap;
  logic              m_upd;
  logic [USER_W-1:0] m_upd_data;

  int checks = 0;
  int errors = 0;
  int cap_seen = 0;
  int upd_seen = 0;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input bit t);
    case (s)
      S_TLR:     return t ? S_TLR     : S_RTI;
      S_RTI:     return t ? S_SELDR   : S_RTI;
      S_SELDR:   return t ? S_SELIR   : S_CAPDR;
      S_CAPDR:   return t ? S_EX1DR   : S_SHDR;
      S_SHDR:    return t ? S_EX1DR   : S_SHDR;
      S_EX1DR:   return t ? S_UPDDR   : S_PAUSEDR;
      S_PAUSEDR: return t ? S_EX2DR   : S_PAUSEDR;
      S_EX2DR:   return t ? S_UPDDR   : S_SHDR;
      S_UPDDR:   return t ? S_SELDR   : S_RTI;
      S_SELIR:   return t ? S_TLR     : S_CAPIR;
      S_CAPIR:   return t ? S_EX1IR   : S_SHIR;
      S_SHIR:    return t ? S_EX1IR   : S_SHIR;
      S_EX1IR:   return t ? S_UPDIR   : S_PAUSEIR;
      S_PAUSEIR: return t ? S_EX2IR   : S_PAUSEIR;
      S_EX2IR:   return t ? S_UPDIR   : S_SHIR;
      default:   return t ? S_SELDR   : S_RTI;
    endcase
  endfunction

  task automatic model_reset();
    m_state    = S_TLR;
    m_ir       = INS_IDCODE;
    m_ir_q     = {};
    for (int i = 0; i < IR_W; i++) m_ir_q.push_back(1'b0);
    m_dr_q     = {};
    m_tdo      = 1'b0;
    m_cap      = 1'b0;
    m_upd      = 1'b0;
    m_upd_data = '0;
  endtask

  task automatic model_rise(input bit t_ms, input bit t_di);
    logic [31:0] val;
    int          w;
    logic [3:0]  nxt;
    if (!trst) return;
    case (m_state)
      S_CAPIR: begin
        m_ir_q = {};
        m_ir_q.push_back(1'b1);
        for (int i = 1; i < IR_W; i++) m_ir_q.push_back(1'b0);
      end
      S_SHIR: begin
        void'(m_ir_q.pop_front());
        m_ir_q.push_back(t_di);
      end
      S_UPDIR: for (int i = 0; i < IR_W; i++) m_ir[i] = m_ir_q[i];
      S_CAPDR: begin
        if (m_ir == INS_IDCODE) begin
          val = IDCODE_VAL; w = 32;
        end else if (m_ir == INS_USER) begin
          val = 32'(cap_data); w = USER_W; m_cap = 1'b1;
        end else begin
          val = 32'd0; w = 1;
        end
        m_dr_q = {};
        for (int i = 0; i < w; i++) m_dr_q.push_back(val[i]);
      end
      S_SHDR: begin
        void'(m_dr_q.pop_front());
        m_dr_q.push_back(t_di);
      end
      S_UPDDR: begin
        if (m_ir == INS_USER) begin
          m_upd = 1'b1;
          for (int i = 0; i < USER_W; i++) m_upd_data[i] = m_dr_q[i];
        end
      end
      default: ;
    endcase
    nxt = tap_next(m_state, t_ms);
    m_state = nxt;
    if (nxt == S_TLR) m_ir = INS_IDCODE;
  endtask

  task automatic model_fall();
    if (!trst) return;
    if (m_state == S_SHIR)      m_tdo = m_ir_q[0];
    else if (m_state == S_SHDR) m_tdo = m_dr_q[0];
    else                        m_tdo = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clk cycle: wait for the sampling edge, compare every output, then
  // retire the one-cycle pulse expectations.
  task automatic tick();
    @(negedge clk);
    if (cap_pulse_o === 1'b1) cap_seen++;
    if (upd_valid_o === 1'b1) upd_seen++;
    chk("tap_state", 32'(tap_state_o), 32'(m_state));
    chk("ir",        32'(ir_o),        32'(m_ir));
    chk("tdo",       32'(tdo_o),       32'(m_tdo));
    chk("cap_pulse", 32'(cap_pulse_o), 32'(m_cap));
    chk("upd_valid", 32'(upd_valid_o), 32'(m_upd));
    chk("upd_data",  32'(upd_data_o),  32'(m_upd_data));
    m_cap = 1'b0;
    m_upd = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tck_cycle(input bit t_ms, input bit t_di, output bit tdo_hi);
    int hp;
    tck = 1'b1; tms = t_ms; tdi = t_di;
    model_rise(t_ms, t_di);
    hp = $urandom_range(2, 4);
    tick();
    tdo_hi = tdo_o;
    repeat (hp - 1) tick();
    tck = 1'b0;
    model_fall();
    hp = $urandom_range(2, 4);
    repeat (hp) tick();
  endtask

  // From RTI: full IR or DR scan of n bits, back to RTI.
  task automatic scan(input bit is_ir, input int n, input logic [31:0] din,
                      output logic [31:0] dout);
    bit b;
    dout = '0;
    tck_cycle(1'b1, 1'b0, b);
    if (is_ir) tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], b);
      dout[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  task automatic pulse_trst(input int n);
    trst = 1'b0;
    m_state = S_TLR;
    m_ir = INS_IDCODE;
    repeat (n) tick();
    trst = 1'b1;
    tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] dout;
    logic [31:0] din;
    logic [3:0]  ins;
    int          cap0, upd0, k;
    bit          b;

    rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; trst = 1'b1; cap_data = '0;
    model_reset();
    repeat (3) tick();
    chk("reset_state", 32'(tap_state_o), 32'hF);
    chk("reset_ir",    32'(ir_o),        32'h1);
    rst = 1'b0;
    tick();

    // TLR via five tms=1 rises, then RTI
    repeat (5) tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    chk("rti_state", 32'(tap_state_o), 32'hC);
    chk("rti_ir",    32'(ir_o),        32'h1);
    chk("rti_tdo",   32'(tdo_o),       32'h0);

    // IDCODE read
    upd0 = upd_seen;
    scan(1'b0, 32, 32'h0, dout);
    chk("idcode_bits", dout, 32'h1000_5A6B);
    chk("idcode_no_upd", 32'(upd_seen - upd0), 32'd0);

    // IR scan of USER
    scan(1'b1, IR_W, 32'h8, dout);
    chk("ir_capture_bits", dout, 32'h1);
    chk("ir_after_upd", 32'(ir_o), 32'h8);

    // USER round trip
    cap0 = cap_seen; upd0 = upd_seen;
    cap_data = 24'hA5A5A5;
    scan(1'b0, USER_W, 32'h123456, dout);
    chk("user_tdo", dout, 32'hA5A5A5);
    chk("user_cap_pulses", 32'(cap_seen - cap0), 32'd1);
    chk("user_upd_pulses", 32'(upd_seen - upd0), 32'd1);
    chk("user_upd_data", 32'(upd_data_o), 32'h123456);

    // USER scan interrupted by Pause/Ex2, resumed without recapture
    cap_data = 24'($urandom);
    din = {8'h0, 24'($urandom)};
    k = 0;
    tck_cycle(1'b1, 1'b0, b); tck_cycle(1'b0, 1'b0, b); tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 11; i++) begin tck_cycle(i == 10, din[k], b); k++; end
    tck_cycle(1'b0, 1'b0, b); tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b); tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 13; i++) begin tck_cycle(i == 12, din[k], b); k++; end
    tck_cycle(1'b1, 1'b0, b); tck_cycle(1'b0, 1'b0, b);
    chk("pause_upd_data", 32'(upd_data_o), din);

    // BYPASS via unlisted opcode 3
    scan(1'b1, IR_W, 32'h3, dout);
    chk("ir_unlisted", 32'(ir_o), 32'h3);
    scan(1'b0, 4, 32'b1101, dout);
    chk("bypass_tdo", dout, 32'b1010);

    // trst in the middle of a USER shift
    scan(1'b1, IR_W, 32'h8, dout);
    upd0 = upd_seen;
    tck_cycle(1'b1, 1'b0, b); tck_cycle(1'b0, 1'b0, b); tck_cycle(1'b0, 1'b0, b);
    repeat (5) tck_cycle(1'b0, 1'($urandom), b);
    trst = 1'b0;
    m_state = S_TLR;
    m_ir = INS_IDCODE;
    tick();
    chk("trst_state", 32'(tap_state_o), 32'hF);
    chk("trst_ir",    32'(ir_o),        32'h1);
    repeat (3) tck_cycle(1'b0, 1'b1, b);
    trst = 1'b1;
    tick();
    chk("trst_hold_state", 32'(tap_state_o), 32'hF);
    chk("trst_no_upd", 32'(upd_seen - upd0), 32'd0);
    tck_cycle(1'b0, 1'b0, b);

    // randomized instruction / data scans
    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(0, 3))
        0: ins = INS_IDCODE;
        1: ins = INS_USER;
        2: ins = INS_BYPASS;
        default: ins = 4'($urandom);
      endcase
      scan(1'b1, IR_W, 32'(ins), dout);
      cap_data = 24'($urandom);
      scan(1'b0, $urandom_range(1, 32), $urandom, dout);
    end

    // random walk over the TAP graph with occasional trst
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 49) == 0) begin
        pulse_trst($urandom_range(1, 3));
      end else begin
        cap_data = 24'($urandom);
        tck_cycle($urandom_range(0, 3) == 0, 1'($urandom), b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
